// File: rtl/pool_pkg.sv
// pool_pkg: definitions shared by pool_window_buffer and max_pooling.
//   POOL_SIZE_DEF / DATA_W_DEF : default window length and sample width
//   pool_win_t                 : packed window vector at the default sizes
//   min_signed(width)          : most negative two's-complement value of
//                                'width' bits (the pad sample), zero-extended
//                                to 64 bits
package pool_pkg;

  localparam int POOL_SIZE_DEF = 2;
  localparam int DATA_W_DEF    = 16;

  typedef logic [POOL_SIZE_DEF*DATA_W_DEF-1:0] pool_win_t;

  function automatic logic [63:0] min_signed(input int width);
    min_signed = 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/pool_window_buffer.sv
// pool_window_buffer: groups POOL_SIZE consecutive signed samples into one
// non-overlapping window and presents it as a packed vector to max_pooling.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   / in_ready / in_data / in_last : sample stream (valid/ready)
//   out_valid  / out_ready / out_data / out_last : window stream; slot i of
//              out_data sits at [i*DATA_W +: DATA_W], slot 0 is the oldest
//   win_count  windows emitted in the current frame, including this one
//   frame_err  sticky: a partial window was dropped
//
// Build option POOL_PAD_PARTIAL_EN: when defined, a frame ending mid-window
// is emitted with the missing slots filled by the most negative sample value;
// otherwise the partial window is dropped and frame_err is raised.
module pool_window_buffer
  import pool_pkg::*;
#(
  parameter int POOL_SIZE = POOL_SIZE_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int WIN_CNT_W = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [POOL_SIZE*DATA_W-1:0] out_data,
  output logic                        out_last,
  output logic [WIN_CNT_W-1:0]        win_count,
  output logic                        frame_err
);

  localparam int                    CNT_W     = $clog2(POOL_SIZE);
  localparam int                    WIN_W     = POOL_SIZE * DATA_W;
  localparam logic [CNT_W-1:0]      LAST_SLOT = CNT_W'(POOL_SIZE - 1);
  localparam logic [63:0]           PAD_FULL  = min_signed(DATA_W);
  localparam logic [DATA_W-1:0]     PAD       = PAD_FULL[DATA_W-1:0];

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // The final slot is never stored: the sample filling it goes straight out.
  logic [DATA_W-1:0]    acc_q [POOL_SIZE-1];
  logic [DATA_W-1:0]    acc_d [POOL_SIZE-1];
  logic [WIN_W-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [WIN_CNT_W-1:0] win_count_q, win_count_d;
  logic                 frame_err_q, frame_err_d;
  // Set by a window that closed a frame, so the next load restarts at 1.
  logic                 frame_end_q, frame_end_d;

  logic                 accept, at_end, complete, load, drop;
  logic [WIN_W-1:0]     win_vec;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign at_end   = (cnt_q == LAST_SLOT);
  assign complete = accept && (at_end || in_last);

`ifdef POOL_PAD_PARTIAL_EN
  assign load = complete;
  assign drop = 1'b0;
`else
  assign load = complete && at_end;
  assign drop = complete && !at_end;
`endif

  // Window as it would look if the current sample closes it: stored slots
  // below cnt, the live sample at cnt, pad above.
  always_comb begin
    win_vec = '0;
    for (int i = 0; i < POOL_SIZE - 1; i++) begin
      if (CNT_W'(i) < cnt_q)       win_vec[i*DATA_W +: DATA_W] = acc_q[i];
      else if (CNT_W'(i) == cnt_q) win_vec[i*DATA_W +: DATA_W] = in_data;
      else                         win_vec[i*DATA_W +: DATA_W] = PAD;
    end
    win_vec[(POOL_SIZE-1)*DATA_W +: DATA_W] = at_end ? in_data : PAD;
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    win_count_d = win_count_q;
    frame_err_d = frame_err_q;
    frame_end_d = frame_end_q;

    if (complete)    cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;

    for (int i = 0; i < POOL_SIZE - 1; i++) begin
      if (accept && !complete && (cnt_q == CNT_W'(i))) acc_d[i] = in_data;
    end

    if (load) begin
      out_data_d  = win_vec;
      out_valid_d = 1'b1;
      out_last_d  = in_last;
      win_count_d = frame_end_q ? WIN_CNT_W'(1) : win_count_q + 1'b1;
      frame_end_d = in_last;
    end else if (out_valid_q && out_ready) begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (drop) begin
      win_count_d = '0;
      frame_end_d = 1'b0;
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      for (int i = 0; i < POOL_SIZE - 1; i++) acc_q[i] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      win_count_q <= '0;
      frame_err_q <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      win_count_q <= win_count_d;
      frame_err_q <= frame_err_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign win_count = win_count_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pool_window_buffer.sv
// Bench for pool_window_buffer: a POOL_SIZE=2 instance driven from a vector
// table, and a POOL_SIZE=4 instance driven by a hand sequence and a random
// stream scored against a queue-based window model.
module tb_pool_window_buffer;

`ifdef POOL_PAD_PARTIAL_EN
  localparam bit HAS_PAD = 1'b1;
`else
  localparam bit HAS_PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // POOL_SIZE=2 instance
  logic        iv2 = 0, il2 = 0, ordy2 = 1;
  logic [15:0] id2 = '0;
  logic        ir2, ov2, ol2, err2;
  logic [31:0] od2;
  logic [11:0] wc2;

  pool_window_buffer #(.POOL_SIZE(2), .DATA_W(16), .WIN_CNT_W(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .in_last(il2), .out_valid(ov2), .out_ready(ordy2), .out_data(od2),
    .out_last(ol2), .win_count(wc2), .frame_err(err2));

  // POOL_SIZE=4 instance
  logic        iv4 = 0, il4 = 0, ordy4 = 1;
  logic [15:0] id4 = '0;
  logic        ir4, ov4, ol4, err4;
  logic [63:0] od4;
  logic [11:0] wc4;

  pool_window_buffer #(.POOL_SIZE(4), .DATA_W(16), .WIN_CNT_W(12)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .in_last(il4), .out_valid(ov4), .out_ready(ordy4), .out_data(od4),
    .out_last(ol4), .win_count(wc4), .frame_err(err4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, iv;
    logic [15:0] d;
    logic        l, ordy;
    logic        e_ir, e_ov;
    logic [31:0] e_od;
    logic        e_ol;
    logic [11:0] e_wc;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic iv, logic [15:0] d, logic l, logic ordy,
                              logic e_ir, logic e_ov, logic [31:0] e_od, logic e_ol,
                              logic [11:0] e_wc, logic e_err);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = d; v.l = l; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol;
    v.e_wc = e_wc; v.e_err = e_err;
    return v;
  endfunction

  task automatic p4(input logic v, input logic [15:0] d, input logic l, input logic r);
    iv4 = v; id4 = d; il4 = l; ordy4 = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Random-test model state
  logic [15:0] pend[$];
  logic [63:0] exp_win[$];
  logic        exp_last[$];

  initial begin
    #1;
    //          rst iv data     l  rdy | ir ov od            ol wc err
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1,  1, 0, 32'h0,        0, 0, 0));
    // stream 3,7,-2,5(last)
    tbl.push_back(mk(0, 1, 16'd3,    0, 1,  1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 16'd7,    0, 1,  1, 1, 32'h00070003, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'hFFFE, 0, 1,  1, 0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 1, 16'd5,    1, 1,  1, 1, 32'h0005FFFE, 1, 2, 0));
    tbl.push_back(mk(0, 0, 16'd0,    0, 1,  1, 0, 32'h0,        0, 2, 0));
    // partial frame 1,2,9(last)
    tbl.push_back(mk(0, 1, 16'd1,    0, 1,  1, 0, 32'h0,        0, 2, 0));
    tbl.push_back(mk(0, 1, 16'd2,    0, 1,  1, 1, 32'h00020001, 0, 1, 0));
    if (HAS_PAD)
      tbl.push_back(mk(0, 1, 16'd9,  1, 1,  1, 1, 32'h80000009, 1, 2, 0));
    else
      tbl.push_back(mk(0, 1, 16'd9,  1, 1,  1, 0, 32'h0,        0, 0, 1));
    tbl.push_back(mk(0, 0, 16'd0,    0, 1,  1, 0, 32'h0,        0, HAS_PAD ? 12'd2 : 12'd0, !HAS_PAD));
    // backpressure
    tbl.push_back(mk(1, 0, 16'd0,    0, 1,  1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 16'd3,    0, 1,  1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 16'd7,    0, 0,  1, 1, 32'h00070003, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'hFFFE, 0, 0,  0, 1, 32'h00070003, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'hFFFE, 0, 0,  0, 1, 32'h00070003, 0, 1, 0));
    tbl.push_back(mk(0, 1, 16'hFFFE, 0, 1,  1, 0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 1, 16'd5,    0, 1,  1, 1, 32'h0005FFFE, 0, 2, 0));
    // reset mid-window: 4 is accepted then discarded by reset
    tbl.push_back(mk(0, 1, 16'd4,    0, 1,  1, 0, 32'h0,        0, 2, 0));
    tbl.push_back(mk(1, 1, 16'h0055, 0, 1,  1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 16'd6,    0, 1,  1, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 16'd8,    0, 1,  1, 1, 32'h00080006, 0, 1, 0));
    tbl.push_back(mk(0, 0, 16'd0,    0, 1,  1, 0, 32'h0,        0, 1, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      rst_n = !tbl[k].rst;
      iv2 = tbl[k].iv; id2 = tbl[k].d; il2 = tbl[k].l; ordy2 = tbl[k].ordy;
      #2;
      if (!tbl[k].rst) chk($sformatf("row%0d in_ready", k), 64'(ir2), 64'(tbl[k].e_ir));
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", k), 64'(ov2),  64'(tbl[k].e_ov));
      if (tbl[k].e_ov || tbl[k].rst)
        chk($sformatf("row%0d out_data", k), 64'(od2), 64'(tbl[k].e_od));
      chk($sformatf("row%0d out_last", k),  64'(ol2),  64'(tbl[k].e_ol));
      chk($sformatf("row%0d win_count", k), 64'(wc2),  64'(tbl[k].e_wc));
      chk($sformatf("row%0d frame_err", k), 64'(err2), 64'(tbl[k].e_err));
    end
    iv2 = 0; il2 = 0; ordy2 = 1;
    rst_n = 1'b1;

    // POOL_SIZE=4: partial frame 10,20,30(last), then full frame 1..4(last)
    do_reset();
    p4(1, 16'd10, 0, 1);
    p4(1, 16'd20, 0, 1);
    p4(1, 16'd30, 1, 1);
    if (HAS_PAD) begin
      chk("p4 partial valid", 64'(ov4), 64'd1);
      chk("p4 partial data", od4, 64'h8000_001E_0014_000A);
      chk("p4 partial last", 64'(ol4), 64'd1);
      chk("p4 partial wc", 64'(wc4), 64'd1);
    end else begin
      chk("p4 partial valid", 64'(ov4), 64'd0);
      chk("p4 partial wc", 64'(wc4), 64'd0);
    end
    chk("p4 partial err", 64'(err4), 64'(!HAS_PAD));
    p4(1, 16'd1, 0, 1);
    p4(1, 16'd2, 0, 1);
    p4(1, 16'd3, 0, 1);
    p4(1, 16'd4, 1, 1);
    chk("p4 full valid", 64'(ov4), 64'd1);
    chk("p4 full data", od4, 64'h0004_0003_0002_0001);
    chk("p4 full last", 64'(ol4), 64'd1);
    chk("p4 full wc", 64'(wc4), 64'd1);
    chk("p4 full err sticky", 64'(err4), 64'(!HAS_PAD));
    p4(0, 16'd0, 0, 1);

    // POOL_SIZE=4: 64 random samples, random backpressure, one frame
    do_reset();
    begin
      int idx = 0;
      int drained = 0;
      logic [15:0] cur = 16'($urandom);
      for (int cyc = 0; cyc < 3000 && drained < 16; cyc++) begin
        iv4   = (idx < 64) && ($urandom_range(0, 3) != 0);
        id4   = cur;
        il4   = (idx == 63);
        ordy4 = ($urandom_range(0, 2) != 0);
        #2;
        chk("rand in_ready", 64'(ir4), 64'(!ov4 || ordy4));
        if (ov4 && ordy4) begin
          if (exp_win.size() == 0) begin
            chk("rand unexpected window", 64'(ov4), 64'd0);
          end else begin
            chk($sformatf("rand win%0d data", drained), od4, exp_win.pop_front());
            chk($sformatf("rand win%0d last", drained), 64'(ol4), 64'(exp_last.pop_front()));
            chk($sformatf("rand win%0d wc", drained), 64'(wc4), 64'(drained + 1));
          end
          drained++;
        end
        if (iv4 && ir4) begin
          pend.push_back(cur);
          if (pend.size() == 4) begin
            logic [63:0] w;
            for (int s = 0; s < 4; s++) w[s*16 +: 16] = pend[s];
            exp_win.push_back(w);
            exp_last.push_back(idx == 63);
            pend.delete();
          end
          idx++;
          cur = 16'($urandom);
        end
        @(posedge clk); #1;
      end
      chk("rand windows drained", 64'(drained), 64'd16);
      chk("rand err", 64'(err4), 64'd0);
    end
    iv4 = 0; il4 = 0; ordy4 = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
